stack_engine: RTL and testbench

// - Consumer side of the stack-pointer protocol: accepts push/pop requests from the control unit,

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_sp_core.sv | 58 +++++
 rtl/stack_engine.sv | 170 +++++++++++++++++
 tb/tb_stack_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : stack_pkg                                              |
// | Purpose : Shared types for the stack engine: FSM state encoding  |
// |           and default data width.                                |
// | Ports   : none (package)                                         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package stack_pkg;

  localparam int c_SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    RESP = 2'd3
  } stack_state_e;

endpackage
`default_nettype wire

// File: rtl/stack_sp_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : stack_sp_core                                          |
// | Purpose : Stack pointer register with load/decrement/increment,  |
// |           full/empty flags and tri-state a/b bus drivers.        |
// | Ports   : clk, rst (async active-low); ld/ld_val, dec, inc       |
// |           update controls; oe_a/oe_b bus enables; sp, full,      |
// |           empty status; a/b tri-state buses.                     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module stack_sp_core
  import stack_pkg::*;
#(
  parameter int              SIZE        = c_SIZE_DEFAULT,
  parameter logic [SIZE-1:0] INITIAL_VAL = '0,
  parameter logic [SIZE-1:0] STACK_LIMIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] ld_val,
  input  logic            dec,
  input  logic            inc,
  input  logic            oe_a,
  input  logic            oe_b,
  output logic [SIZE-1:0] sp,
  output logic            full,
  output logic            empty,
  output wire  [SIZE-1:0] a,
  output wire  [SIZE-1:0] b
);

  localparam logic [SIZE-1:0] c_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0] r_sp;

  // Load has priority; the engine never asserts dec and inc together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= INITIAL_VAL;
    end else if (ld) begin
      r_sp <= ld_val;
    end else if (dec) begin
      r_sp <= r_sp - c_ONE;
    end else if (inc) begin
      r_sp <= r_sp + c_ONE;
    end
  end

  assign sp    = r_sp;
  assign full  = (r_sp == STACK_LIMIT);
  assign empty = (r_sp == INITIAL_VAL);

  assign a = oe_a ? r_sp : 'z;
  assign b = oe_b ? r_sp : 'z;

endmodule
`default_nettype wire

// File: rtl/stack_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : stack_engine                                           |
// | Purpose : Accepts push/pop requests, owns SP (pre-decrement push,|
// |           post-increment pop) and performs the memory access.    |
// | Ports   : clk, rst (async active-low); req_* request handshake;  |
// |           resp_* one-cycle completion; sp_ld/sp_in SP load;      |
// |           sp, a/b (tri-state) SP export; mem_* memory bus.       |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module stack_engine
  import stack_pkg::*;
#(
  parameter int              SIZE        = c_SIZE_DEFAULT,
  parameter logic [SIZE-1:0] INITIAL_VAL = '0,
  parameter logic [SIZE-1:0] STACK_LIMIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_push,
  input  logic [SIZE-1:0] req_data,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [SIZE-1:0] resp_data,
  output logic            resp_err,
  input  logic            sp_ld,
  input  logic [SIZE-1:0] sp_in,
  output logic [SIZE-1:0] sp,
  input  logic            oe_a,
  input  logic            oe_b,
  output wire  [SIZE-1:0] a,
  output wire  [SIZE-1:0] b,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam logic [SIZE-1:0] c_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  stack_state_e    r_state;
  logic            r_resp_valid;
  logic [SIZE-1:0] r_resp_data;
  logic            r_resp_err;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [SIZE-1:0] r_mem_addr;
  logic [SIZE-1:0] r_mem_wdata;

  logic [SIZE-1:0] w_sp;
  logic            w_full;
  logic            w_empty;
  logic            w_idle;
  logic            w_ld;
  logic            w_accept;
  logic            w_dec;
  logic            w_inc;

  // An SP load in IDLE blocks acceptance in the same cycle.
  assign w_idle    = (r_state == IDLE);
  assign w_ld      = w_idle && sp_ld;
  assign req_ready = w_idle && !sp_ld;
  assign w_accept  = req_valid && req_ready;
  assign w_dec     = w_accept && req_push && !w_full;
  assign w_inc     = (r_state == POP) && mem_ack;

  stack_sp_core #(
    .SIZE        (SIZE),
    .INITIAL_VAL (INITIAL_VAL),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp_core (
    .clk    (clk),
    .rst    (rst),
    .ld     (w_ld),
    .ld_val (sp_in),
    .dec    (w_dec),
    .inc    (w_inc),
    .oe_a   (oe_a),
    .oe_b   (oe_b),
    .sp     (w_sp),
    .full   (w_full),
    .empty  (w_empty),
    .a      (a),
    .b      (b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (req_push) begin
              if (w_full) begin
                r_state      <= RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
              end else begin
                // Address is the pre-decremented SP, matching the SP update.
                r_state     <= PUSH;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= w_sp - c_ONE;
                r_mem_wdata <= req_data;
              end
            end else begin
              if (w_empty) begin
                r_state      <= RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
                r_resp_data  <= '0;
              end else begin
                r_state    <= POP;
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_sp;
              end
            end
          end
        end
        PUSH: begin
          if (mem_ack) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
          end
        end
        POP: begin
          if (mem_ack) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= mem_rdata;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sp         = w_sp;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_stack_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_stack_engine                                        |
// | Purpose : Self-checking bench for stack_engine with a memory     |
// |           responder and an abstract stack reference model.       |
// | Ports   : none                                                   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_stack_engine;

  localparam int          c_SIZE  = 32;
  localparam logic [31:0] c_INIT  = 32'h100;
  localparam logic [31:0] c_LIMIT = 32'hFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_push = 1'b0;
  logic [31:0] req_data = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        sp_ld = 1'b0;
  logic [31:0] sp_in = '0;
  logic [31:0] sp;
  logic        oe_a = 1'b0;
  logic        oe_b = 1'b0;
  wire  [31:0] a;
  wire  [31:0] b;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  stack_engine #(
    .SIZE        (c_SIZE),
    .INITIAL_VAL (c_INIT),
    .STACK_LIMIT (c_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_push   (req_push),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .sp_ld      (sp_ld),
    .sp_in      (sp_in),
    .sp         (sp),
    .oe_a       (oe_a),
    .oe_b       (oe_b),
    .a          (a),
    .b          (b),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks two cycles after it first sees mem_req.
  logic [31:0] bus_mem [logic [31:0]];
  int          ack_cnt   = 0;
  int          req_rises = 0;
  int          n_writes  = 0;
  logic        prev_req  = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
    if (!rst || !mem_req || mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          bus_mem[mem_addr] = mem_wdata;
          n_writes++;
        end else begin
          mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : 32'h0;
        end
      end
    end
  end

  // Reference model: a downward-growing stack over a sparse memory.
  logic [31:0] mdl_mem [logic [31:0]];
  logic [31:0] mdl_sp = c_INIT;

  task automatic do_op(input logic push, input logic [31:0] d);
    logic        exp_err;
    logic [31:0] exp_data;
    int          rises0, writes0, n;
    exp_data = 32'h0;
    if (push) begin
      exp_err = (mdl_sp == c_LIMIT);
      if (!exp_err) begin
        mdl_sp = mdl_sp - 32'd1;
        mdl_mem[mdl_sp] = d;
      end
    end else begin
      exp_err = (mdl_sp == c_INIT);
      if (!exp_err) begin
        exp_data = mdl_mem.exists(mdl_sp) ? mdl_mem[mdl_sp] : 32'h0;
        mdl_sp = mdl_sp + 32'd1;
      end
    end
    rises0  = req_rises;
    writes0 = n_writes;
    req_valid = 1'b1;
    req_push  = push;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 32'(resp_valid), 32'd1);
    chk(push ? "push_err" : "pop_err", 32'(resp_err), 32'(exp_err));
    if (!push) chk("pop_data", resp_data, exp_data);
    chk("sp_after_op", sp, mdl_sp);
    chk("mem_req_count", 32'(req_rises - rises0), exp_err ? 32'd0 : 32'd1);
    chk("mem_write_count", 32'(n_writes - writes0), (push && !exp_err) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic do_ld(input logic [31:0] v);
    sp_ld = 1'b1;
    sp_in = v;
    @(negedge clk);
    sp_ld = 1'b0;
    mdl_sp = v;
    chk("sp_load", sp, mdl_sp);
  endtask

  initial begin
    int rises0, n;
    repeat (3) @(negedge clk);
    // Reset state while held in reset
    chk("rst_sp", sp, c_INIT);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sp", sp, c_INIT);
    chk("idle_mem_req", 32'(mem_req), 32'd0);

    // Directed push/pop with exact addresses
    do_op(1'b1, 32'hA);
    chk("addr_first_push", bus_mem.exists(32'hFF) ? bus_mem[32'hFF] : 32'hDEAD, 32'hA);
    do_op(1'b1, 32'hB);
    chk("addr_second_push", bus_mem.exists(32'hFE) ? bus_mem[32'hFE] : 32'hDEAD, 32'hB);
    chk("sp_after_pushes", sp, 32'hFE);
    do_op(1'b0, 32'h0);
    chk("first_pop_data", resp_data, 32'hB);
    do_op(1'b0, 32'h0);
    chk("second_pop_data", resp_data, 32'hA);
    do_op(1'b0, 32'h0);  // underflow
    chk("underflow_sp", sp, 32'h100);

    // Fill to the limit, then overflow
    for (int i = 0; i < 5; i++) do_op(1'b1, 32'h10 + 32'(i));
    chk("overflow_sp", sp, 32'hFC);

    // Load wins over a simultaneous request
    rises0 = req_rises;
    sp_ld = 1'b1;
    sp_in = 32'h80;
    req_valid = 1'b1;
    req_push = 1'b1;
    req_data = 32'hC;
    @(posedge clk);
    @(negedge clk);
    sp_ld = 1'b0;
    mdl_sp = 32'h80;
    chk("ld_wins_sp", sp, 32'h80);
    chk("ld_blocks_accept", 32'(req_rises - rises0), 32'd0);
    #1;
    chk("ready_after_ld", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mdl_sp = 32'h7F;
    mdl_mem[32'h7F] = 32'hC;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ld_push_resp", 32'(resp_valid), 32'd1);
    chk("ld_push_sp", sp, 32'h7F);
    chk("ld_push_mem", bus_mem.exists(32'h7F) ? bus_mem[32'h7F] : 32'hDEAD, 32'hC);
    @(negedge clk);

    // Randomized traffic around the legal window
    do_ld(c_INIT);
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) do_ld(32'($urandom_range(32'hFC, 32'h100)));
      else do_op(r < 5, $urandom);
    end

    // Reset while a push waits for mem_ack
    do_ld(32'hFE);
    req_valid = 1'b1;
    req_push = 1'b1;
    req_data = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("push_pending_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    mdl_sp = c_INIT;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_sp", sp, c_INIT);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(1'b0, 32'h0);  // empty after reset

    // Tri-state SP export
    do_ld(32'hFD);
    oe_a = 1'b1;
    oe_b = 1'b0;
    #1;
    chk("a_drives_sp", a, 32'hFD);
    chk("b_released", 32'(b === 32'hFD), 32'd0);
    oe_a = 1'b0;
    oe_b = 1'b1;
    #1;
    chk("b_drives_sp", b, 32'hFD);
    chk("a_released", 32'(a === 32'hFD), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
